// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer_if
// Description : Request/response handshake bundle between a requester and
//               counter_sequencer. The master drives requests and accepts
//               responses; the slave (the sequencer) does the opposite.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_sequencer_if #(
    parameter int INPUT_WIDTH = 8,
    parameter int CYC_WIDTH   = 16
);
    // Request channel: one stop target per handshake
    logic                   req_valid;
    logic                   req_ready;
    logic [INPUT_WIDTH-1:0] req_stop;

    // Response channel: measured run-cycle index plus timeout flag
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [CYC_WIDTH-1:0]   rsp_cycles;
    logic                   rsp_timeout;

    modport master (
        output req_valid,
        output req_stop,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_cycles,
        input  rsp_timeout
    );

    modport slave (
        input  req_valid,
        input  req_stop,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_cycles,
        output rsp_timeout
    );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Drives a stop-value counter. A request loads the stop value,
//               holds the counter in reset for RESET_CYCLES, releases it and
//               counts run cycles until ctr_done (or a timeout), then returns
//               the measured run-cycle index on the response channel.
//               The bus interface must be instantiated with the same
//               INPUT_WIDTH/CYC_WIDTH as this module.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
    parameter int INPUT_WIDTH    = 8,
    parameter int CYC_WIDTH      = 16,
    parameter int RESET_CYCLES   = 2,     // 1..15
    parameter int TIMEOUT_CYCLES = 1000   // < 2**CYC_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              reset_l,
    counter_sequencer_if.slave     bus,
    output logic                   ctr_reset_l,
    output logic [INPUT_WIDTH-1:0] ctr_stop,
    input  wire logic              ctr_done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last value of the reset-hold counter before the counter is released
    localparam logic [3:0]           c_hold_last = 4'(RESET_CYCLES - 1);
    localparam logic [CYC_WIDTH-1:0] c_timeout   = CYC_WIDTH'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] ctr_stop_q, ctr_stop_d;
    logic [CYC_WIDTH-1:0]   rsp_cycles_q, rsp_cycles_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [3:0]             hold_q, hold_d;
    logic [CYC_WIDTH-1:0]   cyc_q, cyc_d;

    // Next-state and datapath updates for the request/measure/response sequence
    always_comb begin
        state_d       = state_q;
        ctr_stop_d    = ctr_stop_q;
        rsp_cycles_d  = rsp_cycles_q;
        rsp_timeout_d = rsp_timeout_q;
        hold_d        = hold_q;
        cyc_d         = cyc_q;

        case (state_q)
            IDLE: begin
                // req_ready is high in IDLE, so req_valid alone is the handshake
                if (bus.req_valid) begin
                    ctr_stop_d = bus.req_stop;
                    hold_d     = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (hold_q == c_hold_last) begin
                    cyc_d   = '0;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            RUN: begin
                // Done is checked first so it wins when it coincides with timeout
                if (ctr_done) begin
                    rsp_cycles_d  = cyc_q;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cyc_q == c_timeout) begin
                    rsp_cycles_d  = c_timeout;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cyc_d = cyc_q + CYC_WIDTH'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight request
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= IDLE;
            ctr_stop_q    <= '0;
            rsp_cycles_q  <= '0;
            rsp_timeout_q <= 1'b0;
            hold_q        <= '0;
            cyc_q         <= '0;
        end else begin
            state_q       <= state_d;
            ctr_stop_q    <= ctr_stop_d;
            rsp_cycles_q  <= rsp_cycles_d;
            rsp_timeout_q <= rsp_timeout_d;
            hold_q        <= hold_d;
            cyc_q         <= cyc_d;
        end
    end

    // Outputs decode purely from registered state, so reset reaches them at once
    assign ctr_reset_l     = (state_q == RUN);
    assign ctr_stop        = ctr_stop_q;
    assign busy            = (state_q != IDLE);
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_cycles  = rsp_cycles_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Self-checking bench. Instance A (TIMEOUT 1000) runs a vector
//               table through a response scoreboard plus back-pressure and
//               mid-run reset sequences; instance B (TIMEOUT 10) covers the
//               timeout and done-versus-timeout corner cases. Each instance
//               faces a behavioural stop-value counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

    localparam int IW   = 8;
    localparam int CW   = 16;
    localparam int RC   = 2;
    localparam int TO_A = 1000;
    localparam int TO_B = 10;

    logic clk     = 1'b0;
    logic reset_l = 1'b1;
    int   errors  = 0;
    int   checks  = 0;
    int   edges   = 0;

    always #5 clk = ~clk;

    // Edge counter used for latency measurement
    always @(posedge clk) edges <= edges + 1;

    counter_sequencer_if #(.INPUT_WIDTH(IW), .CYC_WIDTH(CW)) bus_a ();
    counter_sequencer_if #(.INPUT_WIDTH(IW), .CYC_WIDTH(CW)) bus_b ();

    logic          ctr_reset_l_a, ctr_done_a, busy_a;
    logic          ctr_reset_l_b, ctr_done_b, busy_b;
    logic [IW-1:0] ctr_stop_a, ctr_stop_b;

    counter_sequencer #(
        .INPUT_WIDTH(IW), .CYC_WIDTH(CW), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO_A)
    ) dut_a (
        .clk(clk), .reset_l(reset_l), .bus(bus_a.slave),
        .ctr_reset_l(ctr_reset_l_a), .ctr_stop(ctr_stop_a),
        .ctr_done(ctr_done_a), .busy(busy_a)
    );

    counter_sequencer #(
        .INPUT_WIDTH(IW), .CYC_WIDTH(CW), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO_B)
    ) dut_b (
        .clk(clk), .reset_l(reset_l), .bus(bus_b.slave),
        .ctr_reset_l(ctr_reset_l_b), .ctr_stop(ctr_stop_b),
        .ctr_done(ctr_done_b), .busy(busy_b)
    );

    // Behavioural stop-value counters: sync active-low reset latches stop
    logic [IW-1:0] cnt_a = '0, lstop_a = '0, cnt_b = '0, lstop_b = '0;
    always @(posedge clk) begin
        if (!ctr_reset_l_a) begin
            cnt_a   <= '0;
            lstop_a <= ctr_stop_a;
        end else if (cnt_a != lstop_a) begin
            cnt_a <= cnt_a + 1'b1;
        end
        if (!ctr_reset_l_b) begin
            cnt_b   <= '0;
            lstop_b <= ctr_stop_b;
        end else if (cnt_b != lstop_b) begin
            cnt_b <= cnt_b + 1'b1;
        end
    end
    assign ctr_done_a = (cnt_a == lstop_a);
    assign ctr_done_b = (cnt_b == lstop_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard for instance A responses
    typedef struct {
        logic [CW-1:0] cyc;
        logic          to;
    } exp_t;
    exp_t sb_a[$];

    task automatic push_a(input logic [CW-1:0] cyc, input logic to);
        exp_t e;
        e.cyc = cyc;
        e.to  = to;
        sb_a.push_back(e);
    endtask

    // Every cycle a response is presented it must match the queue head
    always @(negedge clk) begin
        if (reset_l && bus_a.rsp_valid) begin
            if (sb_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_a_unexpected: got cycles %0d with no request pending", bus_a.rsp_cycles);
            end else begin
                check("rsp_a_cycles", bus_a.rsp_cycles, sb_a[0].cyc);
                check("rsp_a_timeout", bus_a.rsp_timeout, sb_a[0].to);
                if (bus_a.rsp_ready) void'(sb_a.pop_front());
            end
        end
    end

    typedef struct {
        logic [IW-1:0] stop;
        int            hold;
        logic [CW-1:0] cyc;
        logic          to;
        int            lat;
    } vec_t;
    vec_t vecs[5];

    task automatic wait_rsp_a();
        int n = 0;
        while (!bus_a.rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    endtask

    task automatic run_a(input vec_t v);
        int acc;
        push_a(v.cyc, v.to);
        bus_a.req_stop  = v.stop;
        bus_a.req_valid = 1'b1;
        bus_a.rsp_ready = (v.hold == 0);
        check("req_ready_a_before", bus_a.req_ready, 1);
        @(posedge clk); #1;
        acc = edges;
        bus_a.req_valid = 1'b0;
        check("ctr_stop_a", ctr_stop_a, v.stop);
        check("busy_a_run", busy_a, 1);
        wait_rsp_a();
        check("lat_a", edges - acc, v.lat);
        repeat (v.hold) begin
            @(posedge clk); #1;
            check("hold_valid_a", bus_a.rsp_valid, 1);
        end
        bus_a.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready_a", bus_a.req_ready, 1);
        check("idle_rsp_valid_a", bus_a.rsp_valid, 0);
    endtask

    task automatic run_b(input logic [IW-1:0] stop, input logic [CW-1:0] ecyc,
                         input logic eto, input int lat);
        int   acc;
        int   n = 0;
        logic prev_rl;
        bus_b.req_stop  = stop;
        bus_b.req_valid = 1'b1;
        bus_b.rsp_ready = 1'b1;
        @(posedge clk); #1;
        acc = edges;
        bus_b.req_valid = 1'b0;
        prev_rl = ctr_reset_l_b;
        while (!bus_b.rsp_valid && n < 200) begin
            prev_rl = ctr_reset_l_b;
            @(posedge clk); #1;
            n++;
        end
        check("lat_b", edges - acc, lat);
        check("rsp_b_cycles", bus_b.rsp_cycles, ecyc);
        check("rsp_b_timeout", bus_b.rsp_timeout, eto);
        check("ctr_reset_l_b_last_run", prev_rl, 1);
        check("ctr_reset_l_b_resp", ctr_reset_l_b, 0);
        @(posedge clk); #1;
        check("idle_rsp_valid_b", bus_b.rsp_valid, 0);
    endtask

    // Watchdog so the bench always ends
    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        vecs[0] = '{stop: 8'd5,   hold: 0, cyc: 16'd5,   to: 1'b0, lat: 8};
        vecs[1] = '{stop: 8'd0,   hold: 0, cyc: 16'd0,   to: 1'b0, lat: 3};
        vecs[2] = '{stop: 8'd255, hold: 0, cyc: 16'd255, to: 1'b0, lat: 258};
        vecs[3] = '{stop: 8'd1,   hold: 2, cyc: 16'd1,   to: 1'b0, lat: 4};
        vecs[4] = '{stop: 8'd17,  hold: 1, cyc: 16'd17,  to: 1'b0, lat: 20};

        bus_a.req_valid = 1'b0; bus_a.req_stop = '0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_stop = '0; bus_b.rsp_ready = 1'b1;

        // Asynchronous reset before any clock edge
        #1 reset_l = 1'b0;
        #2;
        check("rst_state_ctr_reset_l", ctr_reset_l_a, 0);
        check("rst_state_ctr_stop", ctr_stop_a, 0);
        check("rst_state_rsp_cycles", bus_a.rsp_cycles, 0);
        check("rst_state_rsp_timeout", bus_a.rsp_timeout, 0);
        check("rst_state_rsp_valid", bus_a.rsp_valid, 0);
        check("rst_state_busy", busy_a, 0);
        check("rst_state_req_ready", bus_a.req_ready, 1);
        check("rst_state_b_req_ready", bus_b.req_ready, 1);
        repeat (3) @(posedge clk);
        #1 reset_l = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_a(vecs[i]);

        // Back-pressure: response held, second request waits, accepted after handshake
        push_a(16'd3, 1'b0);
        bus_a.req_stop  = 8'd3;
        bus_a.req_valid = 1'b1;
        bus_a.rsp_ready = 1'b0;
        @(posedge clk); #1;
        acc = edges;
        bus_a.req_stop = 8'd7;
        check("bp_req_ready_busy", bus_a.req_ready, 0);
        wait_rsp_a();
        check("bp_lat_first", edges - acc, RC + 3 + 1);
        push_a(16'd7, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid_held", bus_a.rsp_valid, 1);
            check("bp_req_ready_held", bus_a.req_ready, 0);
        end
        bus_a.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_after_hs", busy_a, 0);
        @(posedge clk); #1;
        acc = edges;
        bus_a.req_valid = 1'b0;
        check("bp_second_accepted", busy_a, 1);
        check("bp_second_stop", ctr_stop_a, 7);
        wait_rsp_a();
        check("bp_lat_second", edges - acc, RC + 7 + 1);
        @(posedge clk); #1;
        check("bp_sb_drained", sb_a.size(), 0);

        // Reset pulsed in run cycle 20 of a stop=50 request
        bus_a.req_stop  = 8'd50;
        bus_a.req_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0;
        repeat (RC + 20) @(posedge clk);
        #1;
        check("mid_run_ctr_reset_l", ctr_reset_l_a, 1);
        check("mid_run_count", cnt_a, 20);
        #1 reset_l = 1'b0;
        #1;
        check("async_ctr_reset_l", ctr_reset_l_a, 0);
        check("async_rsp_valid", bus_a.rsp_valid, 0);
        check("async_busy", busy_a, 0);
        check("async_req_ready", bus_a.req_ready, 1);
        @(posedge clk); #1 reset_l = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("no_rsp_after_reset", bus_a.rsp_valid, 0);
        check("idle_after_reset", busy_a, 0);

        // Timeout and done-versus-timeout on instance B
        run_b(8'd200, 16'(TO_B), 1'b1, RC + TO_B + 1);
        run_b(8'd10,  16'd10,    1'b0, RC + 10 + 1);
        run_b(8'd9,   16'd9,     1'b0, RC + 9 + 1);

        check("sb_a_empty_end", sb_a.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
